capture_ctrl: RTL and testbench

Parametrised capture/readback controller for the logic-analyzer core. It is the next generation of the main sampling FSM and adds:
- explicit arm/abort control
- a sample-fill tracker that prevents readback of never-written RAM entries
- a parametrised address/count width
- a done indication and busy flag
Sits between the command decoder, sample RAM and UART transmitter.

---
 rtl/capture_pkg.sv | 18 +
 rtl/capture_ctrl_if.sv | 28 ++
 rtl/capture_div.sv | 35 +++
 rtl/capture_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_capture_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the capture/readback controller.
package capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPost,
    StTx,
    StTxWait
  } state_e;

  localparam int unsigned CmdWidthDef = 32;
  localparam int unsigned CntWidthDef = 16;

  // rd/dly counts are in units of four samples
  localparam int unsigned CntShift = 2;

endpackage

// File: rtl/capture_ctrl_if.sv
// RAM-port and transmitter handshake bundle between capture_ctrl and its peers.
interface capture_ctrl_if #(
  parameter int unsigned DEPTH = 5
);

  logic             we;
  logic [DEPTH-1:0] addr;
  logic             tx_rdy;
  logic             tx_stb;
  logic             tx_sel;

  modport master (
    output we,
    output addr,
    output tx_stb,
    output tx_sel,
    input  tx_rdy
  );

  modport slave (
    input  we,
    input  addr,
    input  tx_stb,
    input  tx_sel,
    output tx_rdy
  );

endinterface

// File: rtl/capture_div.sv
// Sample strobe divider: passes one stb_i in every (div+1); built only with CAPTURE_CTRL_DIV_EN.
module capture_div #(
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 i_stb,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_stb
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_div_cnt;

  assign o_stb = i_stb && (r_div_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_div     <= '0;
      r_div_cnt <= '0;
    end else begin
      if (i_load) begin
        r_div <= i_div;
      end
      if (i_clear) begin
        r_div_cnt <= '0;
      end else if (i_stb) begin
        r_div_cnt <= o_stb ? r_div : r_div_cnt - DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture/readback controller: ring-buffer sampling around a trigger, newest-first readback.
// Optional strobe divider enabled by defining CAPTURE_CTRL_DIV_EN.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH     = 5,
  parameter int unsigned CMD_WIDTH = CmdWidthDef,
  parameter int unsigned CNT_WIDTH = CntWidthDef,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 set_cnt_i,
  input  logic                 set_div_i,
  input  logic [CMD_WIDTH-1:0] cmd_i,
  input  logic                 arm_i,
  input  logic                 run_i,
  input  logic                 abort_i,
  input  logic                 stb_i,
  capture_ctrl_if.master       bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned CW = CNT_WIDTH + CntShift;
  localparam int unsigned FW = DEPTH + 1;
  localparam logic [FW-1:0]    FillMax = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH-1:0] PtrOne  = DEPTH'(1);

  state_e               r_state, w_state_d;
  logic [DEPTH-1:0]     r_wptr, w_wptr_d;
  logic [DEPTH-1:0]     r_rptr, w_rptr_d;
  logic [CW-1:0]        r_cnt, w_cnt_d;
  logic [FW-1:0]        r_fill, w_fill_d;
  logic [CNT_WIDTH-1:0] r_rd, w_rd_d;
  logic [CNT_WIDTH-1:0] r_dly, w_dly_d;
  logic [CW-1:0]        r_tx_len, w_tx_len_d;
  logic                 r_guard, w_guard_d;

  logic          w_stb;
  logic          w_write;
  logic [CW-1:0] w_dly_scaled;
  logic [CW-1:0] w_rd_scaled;
  logic [CW-1:0] w_fill_ext;

  assign w_dly_scaled = CW'(r_dly) << CntShift;
  assign w_rd_scaled  = CW'(r_rd) << CntShift;
  assign w_fill_ext   = CW'(r_fill);

`ifdef CAPTURE_CTRL_DIV_EN
  logic w_div_load;
  logic w_div_clear;

  assign w_div_load  = (r_state == StIdle) && !abort_i && set_div_i;
  assign w_div_clear = (r_state == StIdle) && !abort_i && arm_i;

  capture_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .i_stb  (stb_i),
    .i_load (w_div_load),
    .i_clear(w_div_clear),
    .i_div  (cmd_i[DIV_WIDTH-1:0]),
    .o_stb  (w_stb)
  );
`else
  logic w_unused;

  assign w_unused = ^{set_div_i, cmd_i[DIV_WIDTH-1:0]};
  assign w_stb    = stb_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_state  <= StIdle;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_fill   <= '0;
      r_rd     <= CNT_WIDTH'(1);
      r_dly    <= CNT_WIDTH'(1);
      r_tx_len <= '0;
      r_guard  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_wptr   <= w_wptr_d;
      r_rptr   <= w_rptr_d;
      r_cnt    <= w_cnt_d;
      r_fill   <= w_fill_d;
      r_rd     <= w_rd_d;
      r_dly    <= w_dly_d;
      r_tx_len <= w_tx_len_d;
      r_guard  <= w_guard_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_wptr_d   = r_wptr;
    w_rptr_d   = r_rptr;
    w_cnt_d    = r_cnt;
    w_fill_d   = r_fill;
    w_rd_d     = r_rd;
    w_dly_d    = r_dly;
    w_tx_len_d = r_tx_len;
    w_guard_d  = 1'b0;
    w_write    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.tx_stb = 1'b0;
    bus.tx_sel = 1'b0;
    done_o     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (set_cnt_i) begin
          w_rd_d  = cmd_i[CNT_WIDTH-1:0];
          w_dly_d = cmd_i[2*CNT_WIDTH-1:CNT_WIDTH];
        end
        if (arm_i) begin
          w_state_d = StPre;
          w_fill_d  = '0;
        end
      end
      StPre: begin
        bus.addr = r_wptr;
        w_write  = w_stb;
        // A strobe coinciding with run_i is a pre-trigger sample
        if (run_i) begin
          w_state_d = StPost;
          w_cnt_d   = '0;
        end
      end
      StPost: begin
        bus.addr = r_wptr;
        if (r_cnt == w_dly_scaled) begin
          w_state_d  = StTx;
          w_rptr_d   = r_wptr - PtrOne;
          w_cnt_d    = '0;
          w_tx_len_d = (w_rd_scaled < w_fill_ext) ? w_rd_scaled : w_fill_ext;
        end else if (w_stb) begin
          w_write = 1'b1;
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StTx: begin
        bus.addr   = r_rptr;
        bus.tx_sel = 1'b1;
        if (r_cnt == r_tx_len) begin
          w_state_d = StIdle;
          done_o    = 1'b1;
        end else begin
          bus.tx_stb = 1'b1;
          w_cnt_d    = r_cnt + CW'(1);
          w_state_d  = StTxWait;
          w_guard_d  = 1'b1;
        end
      end
      StTxWait: begin
        bus.addr   = r_rptr;
        bus.tx_sel = 1'b1;
        // First cycle ignores tx_rdy so a stale ready from the previous byte is not seen
        if (!r_guard && bus.tx_rdy) begin
          w_rptr_d  = r_rptr - PtrOne;
          w_state_d = StTx;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_write) begin
      bus.we   = 1'b1;
      w_wptr_d = r_wptr + PtrOne;
      if (r_fill != FillMax) begin
        w_fill_d = r_fill + FW'(1);
      end
    end

    if (abort_i) begin
      w_state_d  = StIdle;
      w_wptr_d   = r_wptr;
      w_rd_d     = r_rd;
      w_dly_d    = r_dly;
      bus.we     = 1'b0;
      bus.tx_stb = 1'b0;
      done_o     = 1'b0;
    end
  end

  assign busy_o = (r_state != StIdle);

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl (divider test runs only with CAPTURE_CTRL_DIV_EN).
module tb_capture_ctrl;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned NENT  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_cnt = 1'b0;
  logic        set_div = 1'b0;
  logic [31:0] cmd = '0;
  logic        arm = 1'b0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        stb = 1'b0;
  logic        busy;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  logic [DEPTH-1:0] wr_q[$];
  logic [DEPTH-1:0] tx_q[$];
  int unsigned      tx_t[$];
  int unsigned      done_cnt = 0;

  capture_ctrl_if #(.DEPTH(DEPTH)) bus ();

  capture_ctrl #(
    .DEPTH    (DEPTH),
    .CMD_WIDTH(32),
    .CNT_WIDTH(16),
    .DIV_WIDTH(24)
  ) dut (
    .clk_i    (clk),
    .rst_in   (rst_n),
    .set_cnt_i(set_cnt),
    .set_div_i(set_div),
    .cmd_i    (cmd),
    .arm_i    (arm),
    .run_i    (run),
    .abort_i  (abort),
    .stb_i    (stb),
    .bus      (bus),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record RAM writes, transmitter starts and done pulses; reset clears the log
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_q.delete();
      tx_q.delete();
      tx_t.delete();
      done_cnt = 0;
    end else begin
      if (bus.we) wr_q.push_back(bus.addr);
      if (bus.tx_stb) begin
        tx_q.push_back(bus.addr);
        tx_t.push_back(cyc);
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_cnt = 1'b0; set_div = 1'b0; arm = 1'b0; run = 1'b0;
    abort = 1'b0; stb = 1'b0; cmd = '0;
    bus.tx_rdy = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_counts(input logic [31:0] v);
    cmd = v; set_cnt = 1'b1;
    step();
    set_cnt = 1'b0; cmd = '0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic strobes(input int n);
    stb = 1'b1;
    repeat (n) step();
    stb = 1'b0;
  endtask

  task automatic run_pulse(input logic with_stb);
    run = 1'b1; stb = with_stb;
    step();
    run = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 2000) begin
      step();
      k++;
    end
    check({tag, "_no_timeout"}, 32'(k < 2000), 1);
    repeat (8) step();
  endtask

  // Expected readback: n entries, newest first from 'first', wrapping mod 32
  task automatic check_tx(input string tag, input int first, input int n);
    check({tag, "_tx_count"}, tx_q.size(), n);
    for (int i = 0; i < n && i < tx_q.size(); i++) begin
      check($sformatf("%s_tx_addr%0d", tag, i), 32'(tx_q[i]),
            32'((first - i + 2 * NENT) % NENT));
    end
  endtask

  initial begin
    bus.tx_rdy = 1'b1;

    // Reset state while rst_in is held low
    rst_n = 1'b0;
    step();
    step();
    check("rst_we", 32'(bus.we), 0);
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_tx_stb", 32'(bus.tx_stb), 0);
    check("rst_tx_sel", 32'(bus.tx_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Default rd=1,dly=1; fifth strobe lands in the POST exit cycle and must not write
    arm_pulse();
    check("arm_busy", 32'(busy), 1);
    run_pulse(1'b0);
    strobes(5);
    wait_done("dflt");
    check("dflt_wr_count", wr_q.size(), 4);
    check_tx("dflt", 3, 4);
    check("dflt_done", done_cnt, 1);
    check("dflt_idle", 32'(busy), 0);
    check("dflt_tx_spacing", tx_t[1] - tx_t[0], 3);

    // rd=2, dly=1
    do_reset();
    set_counts(32'h0001_0002);
    arm_pulse();
    strobes(10);
    run_pulse(1'b0);
    strobes(4);
    wait_done("basic");
    check("basic_wr_count", wr_q.size(), 14);
    check("basic_wr_last", 32'(wr_q[13]), 13);
    check_tx("basic", 13, 8);
    check("basic_done", done_cnt, 1);

    // Fill clamp: rd=16 but only 6 samples written
    do_reset();
    set_counts(32'h0001_0010);
    arm_pulse();
    strobes(2);
    run_pulse(1'b0);
    strobes(4);
    wait_done("clamp");
    check_tx("clamp", 5, 6);
    check("clamp_done", done_cnt, 1);

    // Ring wrap: 44 writes, full 32-entry readback
    do_reset();
    set_counts(32'h0001_0008);
    arm_pulse();
    strobes(40);
    run_pulse(1'b0);
    strobes(4);
    wait_done("wrap");
    check("wrap_wr_count", wr_q.size(), 44);
    check_tx("wrap", 11, 32);

    // run+stb coincide; set_cnt_i in POST must be ignored
    do_reset();
    set_counts(32'h0001_0002);
    arm_pulse();
    strobes(2);
    run_pulse(1'b1);
    strobes(3);
    repeat (4) step();
    check("coin_still_post_tx", tx_q.size(), 0);
    check("coin_still_busy", 32'(busy), 1);
    set_counts(32'h0000_0000);
    repeat (3) step();
    check("coin_setcnt_ignored_tx", tx_q.size(), 0);
    strobes(1);
    wait_done("coin");
    check("coin_wr_count", wr_q.size(), 7);
    check("coin_wr_run", 32'(wr_q[2]), 2);
    check_tx("coin", 6, 7);

    // rd=0, dly=0: immediate exit, done with no transmission
    do_reset();
    set_counts(32'h0000_0000);
    arm_pulse();
    strobes(1);
    run_pulse(1'b0);
    wait_done("zero");
    check("zero_wr_count", wr_q.size(), 1);
    check("zero_tx_count", tx_q.size(), 0);
    check("zero_done", done_cnt, 1);

    // Abort in TX_WAIT after three transmissions
    do_reset();
    set_counts(32'h0001_0002);
    arm_pulse();
    strobes(4);
    run_pulse(1'b0);
    strobes(4);
    begin
      int k = 0;
      while (tx_q.size() < 3 && k < 500) begin
        step();
        k++;
      end
      check("abort_reach_tx3", 32'(k < 500), 1);
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_txwait_busy", 32'(busy), 1);
    check("abort_cycle_tx_stb", 32'(bus.tx_stb), 0);
    check("abort_cycle_done", 32'(done), 0);
    step();
    abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    repeat (10) step();
    check("abort_tx_count", tx_q.size(), 3);
    check("abort_no_done", done_cnt, 0);
    // Write pointer survives the abort
    arm_pulse();
    strobes(1);
    check("abort_wptr_kept", 32'(wr_q[8]), 8);
    abort = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("abort_forces_we", 32'(bus.we), 0);
    step();
    abort = 1'b0; stb = 1'b0;
    check("abort_pre_idle", 32'(busy), 0);
    check("abort_pre_wr_count", wr_q.size(), 9);

`ifdef CAPTURE_CTRL_DIV_EN
    // div=2: of 9 strobes only 1st, 4th and 7th write
    do_reset();
    cmd = 32'd2; set_div = 1'b1;
    step();
    set_div = 1'b0; cmd = '0;
    arm_pulse();
    begin
      logic [8:0] mask = '0;
      for (int i = 0; i < 9; i++) begin
        stb = 1'b1;
        @(negedge clk);
        mask[i] = bus.we;
        step();
      end
      stb = 1'b0;
      check("div_write_mask", 32'(mask), 32'h049);
    end
    check("div_wr_count", wr_q.size(), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
